// File: rtl/life_pkg.sv
// Shared constants and reference functions for the Game-of-Life cell update.
// The functions are used at elaboration time to build the optional lookup table
// (LIFE_ROM_EN build of case_top).
package life_pkg;

  localparam int CENTER_IDX = 4;
  localparam int WINDOW_W   = 9;
  localparam int COUNT_W    = 4;

  // B3/S23: birth on exactly 3 neighbours, survival on 2 or 3
  localparam logic [WINDOW_W-1:0] DEFAULT_BIRTH_MASK   = 9'b000001000;
  localparam logic [WINDOW_W-1:0] DEFAULT_SURVIVE_MASK = 9'b000001100;

  // Number of live cells in the window, centre excluded
  function automatic logic [COUNT_W-1:0] count_live(input logic [WINDOW_W-1:0] nb);
    logic [COUNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WINDOW_W; i++) begin
      if (i != CENTER_IDX) cnt = cnt + COUNT_W'(nb[i]);
    end
    return cnt;
  endfunction

  // Next state of the centre cell for a given window and rule masks
  function automatic logic next_state(input logic [WINDOW_W-1:0] nb,
                                      input logic [WINDOW_W-1:0] birth,
                                      input logic [WINDOW_W-1:0] survive);
    logic [COUNT_W-1:0] cnt;
    cnt = count_live(nb);
    return nb[CENTER_IDX] ? survive[cnt] : birth[cnt];
  endfunction

  // Full truth table, one bit per window code
  function automatic logic [(1 << WINDOW_W)-1:0] build_life_rom(input logic [WINDOW_W-1:0] birth,
                                                                input logic [WINDOW_W-1:0] survive);
    logic [(1 << WINDOW_W)-1:0] rom;
    rom = '0;
    for (int i = 0; i < (1 << WINDOW_W); i++) begin
      rom[i] = next_state(WINDOW_W'(i), birth, survive);
    end
    return rom;
  endfunction

endpackage

// File: rtl/add_top.sv
// Game-of-Life cell update, adder-path only (ignores LIFE_ROM_EN).
// Same ports and cycle behaviour as case_top.
module add_top
  import life_pkg::*;
#(
  parameter logic [WINDOW_W-1:0] BIRTH_MASK   = DEFAULT_BIRTH_MASK,
  parameter logic [WINDOW_W-1:0] SURVIVE_MASK = DEFAULT_SURVIVE_MASK
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WINDOW_W-1:0] neighbors,
  input  logic                in_valid,
  output logic                result,
  output logic                out_valid,
  output logic [COUNT_W-1:0]  live_count
);

  logic [7:0]         w_ring;
  logic [COUNT_W-1:0] w_count;
  logic               w_next;

  logic               r_result;
  logic               r_out_valid;
  logic [COUNT_W-1:0] r_live_count;

  assign w_ring = {neighbors[8:5], neighbors[3:0]};

  life_popcount8 u_popcount (
    .i_bits  (w_ring),
    .o_count (w_count)
  );

  assign w_next = neighbors[CENTER_IDX] ? SURVIVE_MASK[w_count] : BIRTH_MASK[w_count];

  // Capture a valid sample; idle cycles keep the last result and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_live_count <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result     <= w_next;
        r_live_count <= w_count;
      end
    end
  end

  assign result     = r_result;
  assign out_valid  = r_out_valid;
  assign live_count = r_live_count;

endmodule

// File: rtl/life_popcount8.sv
// Combinational 8-input population count built as a three-level adder tree.
module life_popcount8
  import life_pkg::*;
(
  input  logic [7:0]         i_bits,
  output logic [COUNT_W-1:0] o_count
);

  logic [1:0] w_sum2 [4];
  logic [2:0] w_sum3 [2];

  // First level: add adjacent bit pairs
  for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
    assign w_sum2[gi] = {1'b0, i_bits[2*gi]} + {1'b0, i_bits[2*gi+1]};
  end

  // Second level: add adjacent pair sums
  for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
    assign w_sum3[gi] = {1'b0, w_sum2[2*gi]} + {1'b0, w_sum2[2*gi+1]};
  end

  // Final level: 0..8 fits in four bits without saturation
  assign o_count = {1'b0, w_sum3[0]} + {1'b0, w_sum3[1]};

endmodule

// File: rtl/case_top.sv
// Game-of-Life cell update, one window per cycle, one cycle latency.
// Build option: define LIFE_ROM_EN to take the next state from a 512-entry
// table generated from the rule masks; otherwise popcount plus mask select.
// live_count always comes from the shared popcount so both builds match.
module case_top
  import life_pkg::*;
#(
  parameter logic [WINDOW_W-1:0] BIRTH_MASK   = DEFAULT_BIRTH_MASK,
  parameter logic [WINDOW_W-1:0] SURVIVE_MASK = DEFAULT_SURVIVE_MASK
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WINDOW_W-1:0] neighbors,
  input  logic                in_valid,
  output logic                result,
  output logic                out_valid,
  output logic [COUNT_W-1:0]  live_count
);

  logic [7:0]         w_ring;
  logic [COUNT_W-1:0] w_count;
  logic               w_next;

  logic               r_result;
  logic               r_out_valid;
  logic [COUNT_W-1:0] r_live_count;

  // Surrounding cells only; the centre never contributes to the count
  assign w_ring = {neighbors[8:5], neighbors[3:0]};

  life_popcount8 u_popcount (
    .i_bits  (w_ring),
    .o_count (w_count)
  );

`ifdef LIFE_ROM_EN
  localparam logic [(1 << WINDOW_W)-1:0] LIFE_ROM = build_life_rom(BIRTH_MASK, SURVIVE_MASK);
  assign w_next = LIFE_ROM[neighbors];
`else
  assign w_next = neighbors[CENTER_IDX] ? SURVIVE_MASK[w_count] : BIRTH_MASK[w_count];
`endif

  // Capture a valid sample; idle cycles keep the last result and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_live_count <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result     <= w_next;
        r_live_count <= w_count;
      end
    end
  end

  assign result     = r_result;
  assign out_valid  = r_out_valid;
  assign live_count = r_live_count;

endmodule

// File: tb/tb_case_top.sv
// Scoreboard bench for case_top (and add_top alongside it): stimulus pushes
// expected {result, live_count} per valid sample; a monitor pops on out_valid
// and checks held outputs on idle cycles.
module tb_case_top;

  localparam logic [8:0] TB_BIRTH   = 9'b000001000;
  localparam logic [8:0] TB_SURVIVE = 9'b000001100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] neighbors = 9'h000;
  logic       in_valid = 1'b0;

  logic       result, out_valid;
  logic [3:0] live_count;
  logic       a_result, a_out_valid;
  logic [3:0] a_live_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] held = 5'h00;
  logic [4:0] mon_e;
  logic       mon_v;

  always #5 clk = ~clk;

  case_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .neighbors  (neighbors),
    .in_valid   (in_valid),
    .result     (result),
    .out_valid  (out_valid),
    .live_count (live_count)
  );

  add_top dut_add (
    .clk        (clk),
    .rst_n      (rst_n),
    .neighbors  (neighbors),
    .in_valid   (in_valid),
    .result     (a_result),
    .out_valid  (a_out_valid),
    .live_count (a_live_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: count the eight ring bits, then apply B3/S23
  function automatic logic [4:0] model(input logic [8:0] nb);
    logic [3:0] c;
    logic       r;
    c = 4'd0;
    for (int k = 0; k < 9; k++) if (k != 4) c = c + {3'b000, nb[k]};
    r = nb[4] ? TB_SURVIVE[c] : TB_BIRTH[c];
    return {r, c};
  endfunction

  task automatic issue(input logic [8:0] nb, input logic v, input logic [4:0] e);
    @(negedge clk);
    neighbors = nb;
    in_valid  = v;
    if (v) exp_q.push_back(e);
    $display("issue nb=%03h valid=%0b exp_result=%0b exp_count=%0d", nb, v, e[4], e[3:0]);
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      held = 5'h00;
    end else begin
      mon_v = (exp_q.size() != 0);
      mon_e = mon_v ? exp_q.pop_front() : held;
      check("out_valid",        out_valid,    mon_v);
      check("result",           result,       mon_e[4]);
      check("live_count",       live_count,   mon_e[3:0]);
      check("add_out_valid",    a_out_valid,  mon_v);
      check("add_result",       a_result,     mon_e[4]);
      check("add_live_count",   a_live_count, mon_e[3:0]);
      held = mon_e;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, checked without any clock edge dependency
    #2 rst_n = 1'b0;
    #1;
    check("reset_result",     result,     1'b0);
    check("reset_count",      live_count, 4'd0);
    check("reset_out_valid",  out_valid,  1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, expected values worked out by hand
    issue(9'h000, 1'b1, {1'b0, 4'd0});  // dead, 0
    issue(9'h007, 1'b1, {1'b1, 4'd3});  // dead, 3 -> birth
    issue(9'h013, 1'b1, {1'b1, 4'd2});  // live, 2 -> survive
    issue(9'h010, 1'b1, {1'b0, 4'd0});  // live, 0 -> dies
    issue(9'h1FF, 1'b1, {1'b0, 4'd8});  // live, 8 -> dies
    issue(9'h1EF, 1'b1, {1'b0, 4'd8});  // dead, 8
    issue(9'h01F, 1'b1, {1'b0, 4'd4});  // live, 4 -> dies
    issue(9'h00F, 1'b1, {1'b0, 4'd4});  // dead, 4
    issue(9'h017, 1'b1, {1'b1, 4'd3});  // live, 3 -> survive
    issue(9'h003, 1'b1, {1'b0, 4'd2});  // dead, 2

    // Valid toggling: result 1, held 1, then 0
    issue(9'h007, 1'b1, {1'b1, 4'd3});
    issue(9'h000, 1'b0, {1'b1, 4'd3});
    issue(9'h010, 1'b1, {1'b0, 4'd0});
    issue(9'h000, 1'b0, {1'b0, 4'd0});

    // Exhaustive sweep with a reset pulse landing on 0x0A7
    for (int i = 0; i < 512; i++) begin
      if (i == 'h0A7) begin
        @(negedge clk);
        neighbors = 9'h0A7;
        in_valid  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_result",      result,       1'b0);
        check("midreset_count",       live_count,   4'd0);
        check("midreset_out_valid",   out_valid,    1'b0);
        check("midreset_add_result",  a_result,     1'b0);
        check("midreset_add_valid",   a_out_valid,  1'b0);
        $display("reset asserted mid-sweep at nb=0a7");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
      end
      issue(9'(i), 1'b1, model(9'(i)));
    end
    issue(9'h000, 1'b0, 5'h00);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
